// File: rtl/bc_level_reader.sv
// Box-count level reader: scans the 2^s x 2^s region of one BC bank and
// accumulates sum, sum of squares, non-zero count and maximum of the words read.
module bc_level_reader #(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             bank_sel,
    input  logic [3:0]                       side_log,
    input  logic [DATA_LEN-1:0]              rd_data,
    output logic                             rd_en,
    output logic [2*BOX_IDX:0]               rd_addr,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_LEN+2*BOX_IDX-1:0]    sum,
    output logic [2*DATA_LEN+2*BOX_IDX-1:0]  sumsq,
    output logic [2*BOX_IDX:0]               nz_cnt,
    output logic [DATA_LEN-1:0]              max_val
);

    localparam int AW = 2*BOX_IDX + 1;
    localparam int QW = 2*DATA_LEN + 2*BOX_IDX;

    // IDLE: wait for start | SCAN: issue reads | DRAIN: absorb last word | DONE: results valid
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t               state;
    logic [BOX_IDX-1:0]   x;
    logic [BOX_IDX-1:0]   y;
    logic [BOX_IDX-1:0]   mask;
    logic                 bank;
    logic                 vld;

    logic [BOX_IDX-1:0]   start_mask;
    logic [BOX_IDX-1:0]   nx;
    logic [BOX_IDX-1:0]   ny;
    logic                 last_x;
    logic                 last_y;
    logic [QW-1:0]        sq;
    logic [AW-1:0]        nz_inc;

    // Bit i of the mask is set when s > i, which also clamps s to BOX_IDX.
    always_comb begin
        start_mask = '0;
        for (int i = 0; i < BOX_IDX; i++) begin
            start_mask[i] = (side_log > 4'(i));
        end
    end

    always_comb begin
        last_x = (x == mask);
        last_y = (y == mask);
        nx     = last_x ? '0 : x + BOX_IDX'(1);
        ny     = last_x ? y + BOX_IDX'(1) : y;
        sq     = QW'(rd_data) * QW'(rd_data);
        nz_inc = AW'(rd_data != '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            mask    <= '0;
            bank    <= 1'b0;
            vld     <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            sumsq   <= '0;
            nz_cnt  <= '0;
            max_val <= '0;
        end else if (abort) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            mask    <= '0;
            bank    <= 1'b0;
            vld     <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            sumsq   <= '0;
            nz_cnt  <= '0;
            max_val <= '0;
        end else begin
            vld <= rd_en;
            if (vld) begin
                sum    <= sum + (DATA_LEN+2*BOX_IDX)'(rd_data);
                sumsq  <= sumsq + sq;
                nz_cnt <= nz_cnt + nz_inc;
                if (rd_data > max_val) begin
                    max_val <= rd_data;
                end
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= SCAN;
                        bank    <= bank_sel;
                        mask    <= start_mask;
                        x       <= '0;
                        y       <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= {BOX_IDX'(0), bank_sel, BOX_IDX'(0)};
                        busy    <= 1'b1;
                        sum     <= '0;
                        sumsq   <= '0;
                        nz_cnt  <= '0;
                        max_val <= '0;
                    end
                end
                SCAN: begin
                    if (last_x && last_y) begin
                        state   <= DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        x       <= nx;
                        y       <= ny;
                        rd_addr <= {nx, bank, ny};
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bc_level_reader.sv
// Scoreboard bench for bc_level_reader: a memory model answers reads, stimulus
// pushes expected results, and a negedge monitor checks timing, addresses and results.
module tb_bc_level_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        bank_sel = 1'b0;
    logic [3:0]  side_log = 4'd0;
    logic [7:0]  rd_data = 8'd0;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [13:0] sum;
    logic [21:0] sumsq;
    logic [6:0]  nz_cnt;
    logic [7:0]  max_val;

    bc_level_reader #(.BOX_IDX(3), .DATA_LEN(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .bank_sel(bank_sel), .side_log(side_log), .rd_data(rd_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .busy(busy), .done(done),
        .sum(sum), .sumsq(sumsq), .nz_cnt(nz_cnt), .max_val(max_val)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [0:127];
    always @(posedge CLK) rd_data <= rd_en ? mem[rd_addr] : 8'hA5;

    int edge_cnt = 0;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int sum;
        int sumsq;
        int nz;
        int mx;
        int lat;
        int e0;
    } exp_t;
    exp_t sb_q[$];

    int tests = 0;
    int fails = 0;

    bit         trk_on = 1'b0;
    int         trk_e0, trk_n, trk_s;
    logic [2:0] trk_mask;
    logic       trk_bank;
    logic [6:0] last_addr = 7'd0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int         r, idx, ex, ey;
    logic [6:0] ea;
    exp_t       e;
    always @(negedge CLK) begin
        if (!RST) begin
            if (trk_on) begin
                r = edge_cnt - trk_e0;
                if (r >= 1 && r <= trk_n + 2) begin
                    chk("busy", int'(busy), int'(r <= trk_n + 1));
                    if (r <= trk_n) begin
                        idx = r - 1;
                        ex  = idx & int'(trk_mask);
                        ey  = (idx >> trk_s) & int'(trk_mask);
                        ea  = {3'(ex), trk_bank, 3'(ey)};
                        chk("rd_en_scan", int'(rd_en), 1);
                        chk("rd_addr", int'(rd_addr), int'(ea));
                        last_addr = rd_addr;
                    end else begin
                        chk("rd_en_idle", int'(rd_en), 0);
                        chk("rd_addr_idle", int'(rd_addr), 0);
                    end
                end
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: actual=1 required=0 at edge %0d", edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    chk("sum", int'(sum), e.sum);
                    chk("sumsq", int'(sumsq), e.sumsq);
                    chk("nz_cnt", int'(nz_cnt), e.nz);
                    chk("max_val", int'(max_val), e.mx);
                    chk("done_cycle", edge_cnt - e.e0, e.lat);
                end
            end
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 128; a++) mem[a] = v;
    endtask

    // Drive start for one cycle; leaves the bench at cycle 1 of the scan.
    task automatic issue(input int s, input bit bank, input bit push,
                         input int es, input int eq, input int en, input int em);
        int sc;
        exp_t x;
        @(posedge CLK); #2;
        sc = (s > 3) ? 3 : s;
        start    = 1'b1;
        bank_sel = bank;
        side_log = 4'(s);
        trk_e0   = edge_cnt;
        trk_s    = sc;
        trk_n    = 1 << (2 * sc);
        trk_mask = 3'((1 << sc) - 1);
        trk_bank = bank;
        trk_on   = 1'b1;
        if (push) begin
            x.sum = es; x.sumsq = eq; x.nz = en; x.mx = em;
            x.lat = trk_n + 2; x.e0 = trk_e0;
            sb_q.push_back(x);
        end
        @(posedge CLK); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(posedge CLK); #2;
            t++;
        end
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: actual=no done required=done within 3000 cycles");
            sb_q.delete();
        end
        trk_on = 1'b0;
    endtask

    task automatic wait_cycle(input int c);
        int t = 0;
        while ((edge_cnt - trk_e0) < c && t < 1000) begin
            @(posedge CLK); #2;
            t++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_sum"}, int'(sum), 0);
        chk({tag, "_sumsq"}, int'(sumsq), 0);
        chk({tag, "_nz_cnt"}, int'(nz_cnt), 0);
        chk({tag, "_max_val"}, int'(max_val), 0);
    endtask

    initial begin
        int rs, rq, rn, rm, v;
        fill(8'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        chk_zero("reset");

        // s=3 bank 1, all ones
        fill(8'd1);
        issue(3, 1'b1, 1'b1, 64, 64, 64, 1);
        wait_done();
        repeat (3) @(posedge CLK);
        #2;
        chk("hold_sum", int'(sum), 64);
        chk("hold_nz", int'(nz_cnt), 64);

        // single 255 at (7,7) bank 1
        fill(8'd0);
        mem[7'b111_1_111] = 8'd255;
        issue(3, 1'b1, 1'b1, 255, 65025, 1, 255);
        wait_done();
        chk("last_addr", int'(last_addr), 7'h7F);

        // all 255, no overflow
        fill(8'd255);
        issue(3, 1'b0, 1'b1, 16320, 4161600, 64, 255);
        wait_done();

        // s=1 words 3,0,5,2 in x-fastest order, junk elsewhere
        fill(8'd9);
        mem[7'd0] = 8'd3;  mem[7'd16] = 8'd0;
        mem[7'd1] = 8'd5;  mem[7'd17] = 8'd2;
        issue(1, 1'b0, 1'b1, 10, 38, 3, 5);
        wait_done();

        // s=0: single read at {0,1,0}
        fill(8'd9);
        mem[7'd8] = 8'd7;
        issue(0, 1'b1, 1'b1, 7, 49, 1, 7);
        wait_done();

        // s=9 clamps to 3; ramp data in bank 1
        for (int a = 0; a < 128; a++) mem[a] = 8'(a);
        rs = 0; rq = 0; rn = 0; rm = 0;
        for (int yy = 0; yy < 8; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                v = xx * 16 + 8 + yy;
                rs += v; rq += v * v;
                if (v != 0) rn++;
                if (v > rm) rm = v;
            end
        end
        issue(9, 1'b1, 1'b1, rs, rq, rn, rm);
        wait_done();

        // abort at cycle 20: IDLE next cycle, cleared, no done
        fill(8'd1);
        issue(3, 1'b1, 1'b0, 0, 0, 0, 0);
        wait_cycle(20);
        chk("pre_abort_busy", int'(busy), 1);
        abort  = 1'b1;
        trk_on = 1'b0;
        @(posedge CLK); #2;
        abort = 1'b0;
        chk_zero("abort");
        repeat (80) @(posedge CLK);
        #2;
        issue(3, 1'b1, 1'b1, 64, 64, 64, 1);
        wait_done();

        // start re-pulsed at cycle 10 with new bank/side: ignored
        issue(3, 1'b1, 1'b1, 64, 64, 64, 1);
        wait_cycle(10);
        start = 1'b1; bank_sel = 1'b0; side_log = 4'd1;
        @(posedge CLK); #2;
        start = 1'b0;
        wait_done();

        // abort and start together in IDLE: stays idle
        @(posedge CLK); #2;
        start = 1'b1; abort = 1'b1; side_log = 4'd3; bank_sel = 1'b1;
        @(posedge CLK); #2;
        start = 1'b0; abort = 1'b0;
        chk_zero("abort_start");
        repeat (5) @(posedge CLK);
        #2;
        chk("abort_start_idle", int'(busy), 0);

        // RST mid-scan clears outputs asynchronously
        issue(3, 1'b1, 1'b0, 0, 0, 0, 0);
        wait_cycle(30);
        trk_on = 1'b0;
        chk("pre_rst_sum", int'(sum != 0), 1);
        #1 RST = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge CLK); #2;
        RST = 1'b0;

        // recovery after reset
        fill(8'd9);
        mem[7'd0] = 8'd3;  mem[7'd16] = 8'd0;
        mem[7'd1] = 8'd5;  mem[7'd17] = 8'd2;
        issue(1, 1'b0, 1'b1, 10, 38, 3, 5);
        wait_done();

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bc_level_reader.md
Name: bc_level_reader

Overview:
- Reads back one level of the box-count (BC) memory that the 2x2 aggregation stage has written.
- Scans the 2^s x 2^s occupied region of a selected bank and accumulates the per-level statistics the MFA back-end needs: sum, sum of squares (partition function at q=2), non-zero box count and maximum.
- It is the read-side consumer of the BC write port.
- It uses the same address format as the writer: addr = {x, bank, y}.

Parameters:
- BOX_IDX, 3, log2 of the maximum grid side; x and y are each BOX_IDX bits wide.
- DATA_LEN, 8, width of one BC memory word.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- start  in  1  begin a scan; sampled in IDLE only
- abort  in  1  synchronous abort, returns the block to IDLE
- bank_sel  in  1  value driven onto address bit [BOX_IDX]
- side_log  in  4  s, log2 of the scan side; values greater than BOX_IDX are clamped to BOX_IDX
- rd_data  in  DATA_LEN  BC memory read data, valid 1 cycle after rd_en
- rd_en  out  1  BC memory read enable
- rd_addr  out  2*BOX_IDX+1  {x[BOX_IDX-1:0], bank_sel, y[BOX_IDX-1:0]}
- busy  out  1  high from SCAN entry through DRAIN
- done  out  1  one-cycle pulse when results become valid
- sum  out  DATA_LEN+2*BOX_IDX  sum of all words read
- sumsq  out  2*DATA_LEN+2*BOX_IDX  sum of the squares of all words read
- nz_cnt  out  2*BOX_IDX+1  number of words that are non-zero
- max_val  out  DATA_LEN  largest word read

Behaviour:
- Reset (RST async, or abort at a clock edge):
  - State = IDLE.
  - rd_en=0, rd_addr=0, busy=0, done=0, sum=0, sumsq=0, nz_cnt=0, max_val=0.
  - The internal read-valid pipeline bit is cleared.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN when start=1. At that same edge: latch bank_sel and the clamped s, clear all accumulators, set x=y=0.
  - SCAN: rd_en=1 every cycle.
    - Address order: x increments fastest; when x = 2^s-1, x wraps to 0 and y increments.
    - Leave SCAN after issuing cell (x=2^s-1, y=2^s-1) -> DRAIN.
  - DRAIN: rd_en=0. The last returned word is accumulated at the end of this cycle. Then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Accumulation:
  - At each edge where the pipelined valid bit (rd_en delayed by 1) is set:
    - sum += rd_data
    - sumsq += rd_data*rd_data
    - nz_cnt += (rd_data != 0)
    - max_val = max(max_val, rd_data)
  - Widths are sized so that no overflow is possible for 4^BOX_IDX words of all-ones data. No saturation logic.
- Result outputs are registered. They hold their value from the DONE cycle until the next accepted start or an abort/RST.
- Timing: let start be sampled at edge 0 and N = 4^s.
  - rd_en is high during cycles 1..N.
  - DRAIN is cycle N+1.
  - done=1 in cycle N+2.
  - busy is high in cycles 1..N+1.
- rd_addr: upper bits of x and y beyond s stay 0. rd_addr=0 whenever rd_en=0.
- start while busy or in DONE: ignored, with no effect on the ongoing scan.
- abort mid-scan: the next edge returns to IDLE. No done pulse. Results are cleared to 0. Any in-flight read data is discarded.
- abort and start asserted together in IDLE: abort wins and the block stays in IDLE.
- bank_sel and side_log changing during a scan: no effect, because both are latched at start.
- s=0: a single read of {0, bank, 0}; done in cycle 3.

Test Plan:
- s=3, bank 1, all 64 words = 1 -> sum=64, sumsq=64, nz_cnt=64, max_val=1. done in cycle 66. rd_addr sequence is {x,1,y}, x-fastest, 64 distinct addresses.
- s=3, only (x=7, y=7)=255, all others 0 -> sum=255, sumsq=65025, nz_cnt=1, max_val=255. The last issued address is 7'b111_1_111.
- s=3, all words = 255 -> sum=16320, sumsq=4161600, nz_cnt=64, max_val=255, with no overflow. Then s=1 with words 3,0,5,2 -> sum=10, sumsq=38, nz_cnt=3, max=5, done in cycle 6.
- s=0 and s=9 (clamped to 3): s=0 gives one read at addr {0,bank,0} and done in cycle 3. s=9 behaves identically to s=3.
- abort at cycle 20 of an s=3 scan -> IDLE the next cycle, outputs 0, no done pulse. A new start then gives correct full results.
- start pulsed again at cycle 10 of a scan -> ignored, done still in cycle 66. RST asserted mid-scan -> outputs go to 0 immediately (asynchronously).
